// File: rtl/action_encoder.sv
// Purpose: two-player button front end. Synchronises and debounces eight raw
// push buttons, latches one pending action per player, and releases each
// pending action as a single-cycle code on every game tick.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   plr_1_btn  player 1 raw buttons [0] left [1] right [2] attack [3] defend
//   plr_2_btn  player 2 raw buttons, same map
//   frz        freeze: clear pending actions, force outputs idle
//   plr_1_act  player 1 action code (registered)
//   plr_2_act  player 2 action code (registered)
//   tick       registered game tick pulse
module action_encoder #(
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned TICK_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] plr_1_btn,
  input  logic [3:0] plr_2_btn,
  input  logic       frz,
  output logic [2:0] plr_1_act,
  output logic [2:0] plr_2_act,
  output logic       tick
);

  localparam int unsigned NB = 8;
  localparam int unsigned NP = 2;
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam int unsigned TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [2:0] ACT_IDLE   = 3'b000;
  localparam logic [2:0] ACT_LEFT   = 3'b001;
  localparam logic [2:0] ACT_RIGHT  = 3'b010;
  localparam logic [2:0] ACT_ATTACK = 3'b011;
  localparam logic [2:0] ACT_DEFEND = 3'b100;

  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] stable_q, stable_d;
  logic [CW-1:0] db_cnt_q [NB];
  logic [CW-1:0] db_cnt_d [NB];
  logic [NB-1:0] rise_c;
  logic [2:0]    pend_q [NP];
  logic [2:0]    pend_d [NP];
  logic [2:0]    act_q  [NP];
  logic [2:0]    act_d  [NP];
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick_now_c;
  logic          tick_q;

  // Simultaneous presses resolve defend > attack > right > left.
  function automatic logic [2:0] encode(input logic [3:0] p);
    if (p[3])      return ACT_DEFEND;
    else if (p[2]) return ACT_ATTACK;
    else if (p[1]) return ACT_RIGHT;
    else if (p[0]) return ACT_LEFT;
    else           return ACT_IDLE;
  endfunction

  // Debounce, press detection, tick counter, pending and output next state.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NB); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        // The DB_CYCLES-th consecutive differing cycle commits the new level.
        if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) stable_d[i] = sync2_q[i];
        else                                   db_cnt_d[i] = db_cnt_q[i] + CW'(1);
      end
    end
    // Using stable_d lets the press load pending on the same edge the level commits.
    rise_c = stable_d & ~stable_q;

    tick_now_c = (tcnt_q == TW'(TICK_CYCLES - 1));
    tcnt_d     = tick_now_c ? '0 : tcnt_q + TW'(1);

    for (int p = 0; p < int'(NP); p++) begin
      pend_d[p] = pend_q[p];
      act_d[p]  = ACT_IDLE;
      if (frz) begin
        pend_d[p] = ACT_IDLE;
      end else begin
        if (tick_now_c) begin
          act_d[p]  = pend_q[p];
          pend_d[p] = ACT_IDLE;
        end
        // A press on the tick_now cycle survives into the next tick.
        if (|rise_c[p*4 +: 4]) pend_d[p] = encode(rise_c[p*4 +: 4]);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < int'(NB); i++) db_cnt_q[i] <= '0;
      for (int p = 0; p < int'(NP); p++) begin
        pend_q[p] <= ACT_IDLE;
        act_q[p]  <= ACT_IDLE;
      end
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync1_q  <= {plr_2_btn, plr_1_btn};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < int'(NB); i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int p = 0; p < int'(NP); p++) begin
        pend_q[p] <= pend_d[p];
        act_q[p]  <= act_d[p];
      end
      tcnt_q <= tcnt_d;
      tick_q <= tick_now_c;
    end
  end

  assign plr_1_act = act_q[0];
  assign plr_2_act = act_q[1];
  assign tick      = tick_q;

endmodule

// File: tb/tb_action_encoder.sv
// Purpose: directed self-checking bench for action_encoder (DB_CYCLES=4,
// TICK_CYCLES=16). Timing is referenced to the cycle where tick is seen high.
module tb_action_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b1, b2;
  logic       frz;
  logic [2:0] a1, a2;
  logic       tk;

  int checks   = 0;
  int failures = 0;
  bit spur     = 1'b0;

  typedef struct {
    logic [3:0] b1;
    logic [3:0] b2;
    logic [2:0] e1;
    logic [2:0] e2;
  } vec_t;

  vec_t vecs [10];

  action_encoder #(.DB_CYCLES(4), .TICK_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .plr_1_btn (b1),
    .plr_2_btn (b2),
    .frz       (frz),
    .plr_1_act (a1),
    .plr_2_act (a2),
    .tick      (tk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // One clock; any non-idle action seen here is unexpected.
  task automatic step();
    @(posedge clk);
    #1;
    if (a1 !== 3'b000 || a2 !== 3'b000) spur = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance to the next cycle with tick=1 and compare both action codes there.
  task automatic run_to_tick(input logic [2:0] e1, input logic [2:0] e2,
                             input string nm, output int n);
    bit found;
    found = 1'b0;
    n     = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (tk === 1'b1) begin
        found = 1'b1;
        chk({nm, "_p1"}, 32'(a1), 32'(e1));
        chk({nm, "_p2"}, 32'(a2), 32'(e2));
        chk({nm, "_quiet"}, 32'(spur), 32'd0);
        spur = 1'b0;
      end else if (a1 !== 3'b000 || a2 !== 3'b000) begin
        spur = 1'b1;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_tick exp=tick_within_40", nm);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{4'b0001, 4'b0000, 3'b001, 3'b000};
    vecs[1] = '{4'b0010, 4'b1000, 3'b010, 3'b100};
    vecs[2] = '{4'b0100, 4'b0001, 3'b011, 3'b001};
    vecs[3] = '{4'b1000, 4'b0010, 3'b100, 3'b010};
    vecs[4] = '{4'b0011, 4'b0110, 3'b010, 3'b011};
    vecs[5] = '{4'b0111, 4'b1100, 3'b011, 3'b100};
    vecs[6] = '{4'b1111, 4'b1010, 3'b100, 3'b100};
    vecs[7] = '{4'b0101, 4'b1001, 3'b011, 3'b100};
    vecs[8] = '{4'b0000, 4'b1100, 3'b000, 3'b100};
    vecs[9] = '{4'b1100, 4'b0000, 3'b100, 3'b000};

    rst = 1'b0; b1 = '0; b2 = '0; frz = 1'b0;

    // Reset held for three cycles.
    cycles(3);
    chk("rst_p1", 32'(a1), 32'd0);
    chk("rst_p2", 32'(a2), 32'd0);
    chk("rst_tick", 32'(tk), 32'd0);
    rst = 1'b1;

    // First tick lands 16 cycles after release; reset asserted on a tick cycle clears tick at once.
    run_to_tick(3'b000, 3'b000, "first", n);
    chk("first_tick_lat", 32'(n), 32'd16);
    rst = 1'b0;
    #1;
    chk("rst_async_tick", 32'(tk), 32'd0);
    cycles(2);
    rst = 1'b1;

    // Mid-run reset with player 1 pending right: nothing emitted afterwards.
    run_to_tick(3'b000, 3'b000, "pre_rst", n);
    b1 = 4'b0010;
    cycles(10);
    b1 = 4'b0000;
    rst = 1'b0;
    #1;
    chk("midrst_p1", 32'(a1), 32'd0);
    chk("midrst_tick", 32'(tk), 32'd0);
    cycles(2);
    rst = 1'b1;
    run_to_tick(3'b000, 3'b000, "midrst_t1", n);
    run_to_tick(3'b000, 3'b000, "midrst_t2", n);

    // Table: simultaneous presses per player, priority and independence.
    for (int i = 0; i < 10; i++) begin
      run_to_tick(3'b000, 3'b000, $sformatf("vec%0d_pre", i), n);
      b1 = vecs[i].b1;
      b2 = vecs[i].b2;
      run_to_tick(vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i), n);
      b1 = '0;
      b2 = '0;
      cycles(8);
    end

    // Held left: last press slot that still makes this tick, then nothing more.
    run_to_tick(3'b000, 3'b000, "hold_pre", n);
    cycles(9);
    b1 = 4'b0001;
    run_to_tick(3'b001, 3'b000, "hold_t1", n);
    run_to_tick(3'b000, 3'b000, "hold_t2", n);
    chk("tick_period", 32'(n), 32'd16);
    run_to_tick(3'b000, 3'b000, "hold_t3", n);
    b1 = '0;
    cycles(8);

    // Glitches of 3 cycles never pass the 4-cycle debounce.
    run_to_tick(3'b000, 3'b000, "glitch_pre", n);
    for (int r = 0; r < 3; r++) begin
      b2 = 4'b0100;
      cycles(3);
      b2 = 4'b0000;
      cycles(3);
    end
    run_to_tick(3'b000, 3'b000, "glitch", n);
    run_to_tick(3'b000, 3'b000, "glitch2", n);

    // Latest press wins: left then right before the tick.
    run_to_tick(3'b000, 3'b000, "last_pre", n);
    b1 = 4'b0001;
    cycles(4);
    b1 = 4'b0011;
    run_to_tick(3'b010, 3'b000, "last_wins", n);
    b1 = '0;
    cycles(8);

    // Press accepted on the tick_now edge while attack is pending.
    run_to_tick(3'b000, 3'b000, "tnow_pre", n);
    b1 = 4'b0100;
    cycles(8);
    b1 = 4'b0000;
    cycles(2);
    b1 = 4'b0010;
    run_to_tick(3'b011, 3'b000, "tnow_old", n);
    run_to_tick(3'b010, 3'b000, "tnow_new", n);
    b1 = '0;
    cycles(8);

    // Freeze across a tick discards both pendings; held buttons emit nothing later.
    run_to_tick(3'b000, 3'b000, "frz_pre", n);
    b1 = 4'b0001;
    b2 = 4'b0001;
    cycles(8);
    frz = 1'b1;
    run_to_tick(3'b000, 3'b000, "frz_tick", n);
    cycles(4);
    frz = 1'b0;
    run_to_tick(3'b000, 3'b000, "frz_after", n);
    b1 = '0;
    b2 = '0;
    cycles(8);
    run_to_tick(3'b000, 3'b000, "frz_after2", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
